pkt_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one 64-bit tx stream (data/en/sop/eop/byte_vaild, tx_ready backpressure) between N_SRC packet sources.
- Sits between several packet generators or upstream framers and the single raw 10G link transmit interface.
- Grants one source at a time, forwards its beats with one register stage, and releases the grant after EOP.
- A watchdog releases the grant if the granted source stalls.

---
 rtl/pkt_link_pkg.sv | 17 +
 rtl/rr_pick.sv | 31 +++
 rtl/pkt_rr_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_pkt_rr_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_link_pkg.sv
// Shared constants and types for the packet link blocks.
// Beat geometry, arbiter state encoding and sticky error bit positions.
package pkt_link_pkg;

    localparam int unsigned BEAT_W = 64;
    localparam int unsigned BV_W   = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StGap   = 2'd2
    } arb_state_e;

    localparam int unsigned ERR_WDOG  = 0;
    localparam int unsigned ERR_FRAME = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1, wrapping.
// Produces both a one-hot grant and the winner index.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [31:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last) + k) % N;
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid                 = 1'b1;
                gnt[cand[IDX_W-1:0]]  = 1'b1;
                idx                   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered tx beat stream between N_SRC sources.
// Grant is held for a whole packet; a watchdog frees it if the owner stops sending.
module pkt_rr_arbiter
    import pkt_link_pkg::*;
#(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned DATA_W  = BEAT_W,
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 200
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    tx_ready,
    input  logic [N_SRC-1:0]        s_req,
    output logic [N_SRC-1:0]        s_gnt,
    input  logic [N_SRC*DATA_W-1:0] s_data,
    input  logic [N_SRC-1:0]        s_en,
    input  logic [N_SRC-1:0]        s_sop,
    input  logic [N_SRC-1:0]        s_eop,
    input  logic [N_SRC*BV_W-1:0]   s_byte_vaild,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_data_en,
    output logic                    tx_data_sop,
    output logic                    tx_data_eop,
    output logic [BV_W-1:0]         tx_data_byte_vaild,
    output logic [31:0]             pkt_cnt,
    output logic [1:0]              err_sticky
);

    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    arb_state_e        state_q, state_d;
    logic [N_SRC-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [TMO_W-1:0]  wdog_q, wdog_d;
    logic              first_q, first_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [1:0]        err_q, err_d;

    logic [DATA_W-1:0] txd_q, txd_d;
    logic              txen_q, txen_d;
    logic              txsop_q, txsop_d;
    logic              txeop_q, txeop_d;
    logic [BV_W-1:0]   txbv_q, txbv_d;

    logic [N_SRC-1:0]  pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;

    logic [DATA_W-1:0] sel_data;
    logic              sel_en, sel_sop, sel_eop;
    logic [BV_W-1:0]   sel_bv;
    logic              acc;

    rr_pick #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (s_req),
        .last  (last_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // One-hot mux on the registered grant; ungranted sources never reach tx.
    always_comb begin
        sel_data = '0;
        sel_en   = 1'b0;
        sel_sop  = 1'b0;
        sel_eop  = 1'b0;
        sel_bv   = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (gnt_q[i]) begin
                sel_data = s_data[i*DATA_W +: DATA_W];
                sel_en   = s_en[i];
                sel_sop  = s_sop[i];
                sel_eop  = s_eop[i];
                sel_bv   = s_byte_vaild[i*BV_W +: BV_W];
            end
        end
    end

    assign acc = (state_q == StGrant) && sel_en && tx_ready;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        txd_d   = acc ? sel_data : '0;
        txen_d  = acc;
        txsop_d = acc && sel_sop;
        txeop_d = acc && sel_eop;
        txbv_d  = (acc && sel_eop) ? sel_bv : '0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StGrant;
                    gnt_d   = pick_gnt;
                    gidx_d  = pick_idx;
                    wdog_d  = '0;
                    first_d = 1'b1;
                end
            end
            StGrant: begin
                if (acc) begin
                    wdog_d  = '0;
                    first_d = 1'b0;
                    // Framing fault: sop missing on the first beat, or present on a later one.
                    if (first_q != sel_sop) begin
                        err_d[ERR_FRAME] = 1'b1;
                    end
                    if (sel_eop) begin
                        state_d = StGap;
                        gnt_d   = '0;
                        last_d  = gidx_q;
                        cnt_d   = cnt_q + 32'd1;
                    end
                end else if (tx_ready) begin
                    if (wdog_q == TMO_W'(TMO_MAX - 1)) begin
                        state_d         = StGap;
                        gnt_d           = '0;
                        last_d          = gidx_q;
                        wdog_d          = '0;
                        err_d[ERR_WDOG] = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(N_SRC - 1);
            wdog_q  <= '0;
            first_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= '0;
            txd_q   <= '0;
            txen_q  <= 1'b0;
            txsop_q <= 1'b0;
            txeop_q <= 1'b0;
            txbv_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            txd_q   <= txd_d;
            txen_q  <= txen_d;
            txsop_q <= txsop_d;
            txeop_q <= txeop_d;
            txbv_q  <= txbv_d;
        end
    end

    assign s_gnt              = gnt_q;
    assign tx_data            = txd_q;
    assign tx_data_en         = txen_q;
    assign tx_data_sop        = txsop_q;
    assign tx_data_eop        = txeop_q;
    assign tx_data_byte_vaild = txbv_q;
    assign pkt_cnt            = cnt_q;
    assign err_sticky         = err_q;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Self-checking bench for pkt_rr_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a packet-level reference model.
module tb_pkt_rr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int TMO = 200;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic            tx_ready;
    logic [N-1:0]    s_req, s_gnt, s_en, s_sop, s_eop;
    logic [N*DW-1:0] s_data;
    logic [N*3-1:0]  s_bv;
    logic [DW-1:0]   tx_data;
    logic            tx_en, tx_sop, tx_eop;
    logic [2:0]      tx_bv;
    logic [31:0]     pkt_cnt;
    logic [1:0]      err_sticky;

    always #5 sys_clk = ~sys_clk;

    pkt_rr_arbiter #(
        .N_SRC   (N),
        .DATA_W  (DW),
        .TMO_W   (8),
        .TMO_MAX (TMO)
    ) dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .tx_ready           (tx_ready),
        .s_req              (s_req),
        .s_gnt              (s_gnt),
        .s_data             (s_data),
        .s_en               (s_en),
        .s_sop              (s_sop),
        .s_eop              (s_eop),
        .s_byte_vaild       (s_bv),
        .tx_data            (tx_data),
        .tx_data_en         (tx_en),
        .tx_data_sop        (tx_sop),
        .tx_data_eop        (tx_eop),
        .tx_data_byte_vaild (tx_bv),
        .pkt_cnt            (pkt_cnt),
        .err_sticky         (err_sticky)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the link, cycles left before a new grant may be decided.
    int          m_owner, m_last, m_hold, m_idle;
    bit          m_first;
    logic [31:0] m_cnt;
    logic [1:0]  m_err;
    logic [DW-1:0] e_data;
    logic        e_en, e_sop, e_eop;
    logic [2:0]  e_bv;

    // Source behaviour and scenario knobs.
    bit has_pkt[N];
    int len[N], pos[N], pkts_left[N];
    int ready_pct, en_pct, flip_pct, mute_src, stall_cnt, force_bv, fixed_len;
    bit flip_first;

    // Observation helpers.
    int          glog[$];
    logic [N-1:0] prev_gnt;
    logic        prev_eop;
    bit          saw_ones;
    logic [2:0]  last_eop_bv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_next(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic next_packet(input int o);
        flip_first = 1'b0;
        if (pkts_left[o] > 0) begin
            pkts_left[o]--;
            len[o] = (fixed_len > 0) ? fixed_len : int'($urandom_range(6, 1));
            pos[o] = 0;
        end else begin
            has_pkt[o] = 1'b0;
        end
    endtask

    task automatic drive();
        tx_ready = ($urandom_range(99) < ready_pct);
        if (stall_cnt > 0) begin
            tx_ready = 1'b0;
            stall_cnt--;
        end
        for (int i = 0; i < N; i++) begin
            s_req[i] = has_pkt[i] && (m_owner != i);
            if (m_owner == i) s_req[i] = 1'($urandom_range(1));
            if (m_owner == i && has_pkt[i] && i != mute_src && $urandom_range(99) < en_pct) begin
                s_en[i]  = 1'b1;
                s_sop[i] = (pos[i] == 0) && !flip_first;
                if ($urandom_range(99) < flip_pct) s_sop[i] = ~s_sop[i];
                s_eop[i] = (pos[i] == len[i] - 1);
                s_data[i*DW +: DW] = {$urandom, $urandom};
                if (s_eop[i])
                    s_bv[i*3 +: 3] = (force_bv != 0) ? 3'(force_bv) : 3'($urandom_range(7, 1));
                else
                    s_bv[i*3 +: 3] = 3'($urandom_range(7));
            end else begin
                // Idle or ungranted source: noise with all-ones data that must never leak.
                s_en[i]  = (m_owner == i) ? 1'b0 : 1'($urandom_range(1));
                s_sop[i] = 1'($urandom_range(1));
                s_eop[i] = 1'($urandom_range(1));
                s_data[i*DW +: DW] = '1;
                s_bv[i*3 +: 3] = 3'($urandom_range(7));
            end
        end
    endtask

    task automatic model_step();
        int o;
        int w;
        bit acc;
        o   = m_owner;
        acc = (o >= 0) && s_en[o] && tx_ready;
        e_en = acc; e_data = '0; e_sop = 1'b0; e_eop = 1'b0; e_bv = '0;
        if (acc) begin
            e_data = s_data[o*DW +: DW];
            e_sop  = s_sop[o];
            e_eop  = s_eop[o];
            if (s_eop[o]) e_bv = s_bv[o*3 +: 3];
        end
        if (o >= 0) begin
            if (acc) begin
                m_idle = 0;
                if (m_first && !s_sop[o]) m_err[1] = 1'b1;
                if (!m_first && s_sop[o]) m_err[1] = 1'b1;
                m_first = 1'b0;
                pos[o]++;
                if (s_eop[o]) begin
                    m_cnt   = m_cnt + 1;
                    m_last  = o;
                    m_owner = -1;
                    m_hold  = 1;
                    next_packet(o);
                end
            end else if (tx_ready) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_err[0]   = 1'b1;
                    m_last     = o;
                    m_owner    = -1;
                    m_hold     = 1;
                    has_pkt[o] = 1'b0;
                end
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            w = rr_next(s_req, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_idle  = 0;
                m_first = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("gnt", 64'(s_gnt), 64'(eg));
        chk("tx_en", 64'(tx_en), 64'(e_en));
        chk("tx_data", tx_data, e_data);
        chk("tx_sop", 64'(tx_sop), 64'(e_sop));
        chk("tx_eop", 64'(tx_eop), 64'(e_eop));
        chk("tx_bv", 64'(tx_bv), 64'(e_bv));
        chk("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
        chk("err", 64'(err_sticky), 64'(m_err));
        if (prev_eop) chk("gap", 64'(tx_en), 64'd0);
        if (s_gnt != '0 && s_gnt != prev_gnt) begin
            for (int i = 0; i < N; i++) if (s_gnt[i]) glog.push_back(i);
        end
        if (tx_data == '1) saw_ones = 1'b1;
        if (tx_eop) last_eop_bv = tx_bv;
        prev_gnt = s_gnt;
        prev_eop = tx_eop;
    endtask

    task automatic cycle();
        drive();
        model_step();
        @(posedge sys_clk);
        #1;
        check_outputs();
    endtask

    task automatic run_drain(input int max_cycles);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < max_cycles) begin
            cycle();
            n++;
            busy = (m_owner >= 0) || (m_hold > 0);
            for (int i = 0; i < N; i++) if (has_pkt[i]) busy = 1'b1;
        end
        chk("drain", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        sys_rst  = 1'b1;
        tx_ready = 1'b0;
        s_req = '0; s_en = '0; s_sop = '0; s_eop = '0; s_data = '0; s_bv = '0;
        m_owner = -1; m_last = N - 1; m_hold = 0; m_idle = 0; m_first = 1'b0;
        m_cnt = '0; m_err = '0;
        e_data = '0; e_en = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_bv = '0;
        for (int i = 0; i < N; i++) begin
            has_pkt[i] = 1'b0; len[i] = 3; pos[i] = 0; pkts_left[i] = 0;
        end
        ready_pct = 100; en_pct = 100; flip_pct = 0; mute_src = -1;
        stall_cnt = 0; force_bv = 0; fixed_len = 3; flip_first = 1'b0;
        glog.delete();
        prev_gnt = '0; prev_eop = 1'b0; saw_ones = 1'b0; last_eop_bv = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    initial begin
        int n;

        // Reset state.
        do_reset();
        chk("rst_gnt", 64'(s_gnt), 64'd0);
        chk("rst_tx_en", 64'(tx_en), 64'd0);
        chk("rst_tx_data", tx_data, 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_err", 64'(err_sticky), 64'd0);

        // All four request, 3-beat packets, source 0 has a second packet.
        for (int i = 0; i < N; i++) has_pkt[i] = 1'b1;
        pkts_left[0] = 1;
        run_drain(200);
        chk("rr_count", 64'(glog.size()), 64'd5);
        if (glog.size() == 5) begin
            chk("rr_g0", 64'(glog[0]), 64'd0);
            chk("rr_g1", 64'(glog[1]), 64'd1);
            chk("rr_g2", 64'(glog[2]), 64'd2);
            chk("rr_g3", 64'(glog[3]), 64'd3);
            chk("rr_g4", 64'(glog[4]), 64'd0);
        end
        chk("rr_pkt_cnt", 64'(pkt_cnt), 64'd5);
        chk("no_leak", 64'(saw_ones), 64'd0);

        // Source 2 alone, 4-cycle tx_ready stall mid-packet, eop byte code 5.
        do_reset();
        has_pkt[2] = 1'b1; len[2] = 5; force_bv = 5;
        repeat (4) cycle();
        stall_cnt = 4;
        run_drain(100);
        chk("stall_bv", 64'(last_eop_bv), 64'd5);
        chk("stall_err", 64'(err_sticky), 64'd0);
        chk("stall_cnt", 64'(pkt_cnt), 64'd1);

        // Source 1 granted but silent: watchdog release, then source 2.
        do_reset();
        has_pkt[1] = 1'b1; has_pkt[2] = 1'b1; len[2] = 2; mute_src = 1;
        run_drain(400);
        chk("wd_err", 64'(err_sticky), 64'd1);
        chk("wd_cnt", 64'(pkt_cnt), 64'd1);
        chk("wd_order_n", 64'(glog.size()), 64'd2);
        if (glog.size() == 2) chk("wd_next", 64'(glog[1]), 64'd2);

        // Single-beat sop+eop is legal; a first beat without sop is a framing error.
        do_reset();
        has_pkt[0] = 1'b1; len[0] = 1;
        run_drain(50);
        chk("frm_single_err", 64'(err_sticky), 64'd0);
        has_pkt[0] = 1'b1; len[0] = 3; pos[0] = 0; flip_first = 1'b1;
        run_drain(50);
        chk("frm_nosop_err", 64'(err_sticky), 64'd2);
        chk("frm_cnt", 64'(pkt_cnt), 64'd2);

        // Randomized traffic with backpressure, gaps and occasional framing faults.
        do_reset();
        ready_pct = 80; en_pct = 75; flip_pct = 3; fixed_len = 0;
        for (int i = 0; i < N; i++) begin
            has_pkt[i]   = 1'($urandom_range(1));
            len[i]       = int'($urandom_range(6, 1));
            pkts_left[i] = int'($urandom_range(40, 10));
        end
        run_drain(6000);
        chk("rand_no_leak", 64'(saw_ones), 64'd0);

        // Reset asserted mid-packet clears outputs without waiting for a clock.
        do_reset();
        has_pkt[1] = 1'b1; len[1] = 6;
        repeat (4) cycle();
        #2;
        sys_rst = 1'b1;
        #1;
        chk("amid_gnt", 64'(s_gnt), 64'd0);
        chk("amid_tx_en", 64'(tx_en), 64'd0);
        chk("amid_tx_data", tx_data, 64'd0);
        chk("amid_tx_eop", 64'(tx_eop), 64'd0);
        do_reset();
        for (int i = 0; i < N; i++) has_pkt[i] = 1'b1;
        n = 0;
        while (glog.size() == 0 && n < 10) begin
            cycle();
            n++;
        end
        chk("post_rst_first", 64'((glog.size() > 0) ? glog[0] : -1), 64'd0);
        run_drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
